instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Inverse of the instruction categorizer: takes {category, sub-op, fields} encode requests
//  and emits 32-bit MIPS instruction words. Used by the program generator and self-test
//  paths to feed the fetch stage.
//  Request FIFO feeds one registered encode stage; valid/ready on both ends.
//  Illegal requests are flagged and counted.
// PARAMETERS
//  DEPTH     4    request FIFO entries; power of 2, >= 2
//  CNT_W     16   width of outCount / illegalCount
// PORTS
//  clock        in   1      sole clock, rising edge
//  reset        in   1      synchronous, active-high
//  inValid      in   1      request valid
//  inReady      out  1      request accepted when inValid & inReady at clock edge
//  inCategory   in   CAT_W  `Instruction_Category_T` value (*_V constants)
//  inSub        in   3      sub-op index within category
//  inRs/inRt/inRd in 5 each register fields
//  inShamt      in   5      shift amount (R-type)
//  inImm        in   26     imm[15:0] for I-type; full 26 bits = J target
//  outValid     out  1      outWord valid
//  outReady     in   1      consumer accepts when outValid & outReady
//  outWord      out  32     encoded instruction
//  outIllegal   out  1      request was not encodable; outWord = 32'h0
//  level        out  $clog2(DEPTH)+1  FIFO occupancy
//  outCount     out  CNT_W  words delivered (wraps)
//  illegalCount out  CNT_W  illegal words delivered (saturates at all-ones)
// BEHAVIOUR
//  Reset: FIFO empty, level=0, outValid=0, outWord=0, outIllegal=0, counters=0; inReady=1
//   in first cycle after reset. Reset mid-stream discards FIFO and output register.
//  inReady = (level != DEPTH); independent of same-cycle pop (no push-through when full).
//  Output reg loads FIFO head when level!=0 && (!outValid || outReady); else holds.
//   Word/illegal stable while outValid & !outReady.
//  Latency: request pushed at edge k -> outValid at edge k+1 if output path free.
//   Throughput 1/cycle. Order preserved.
//  Capacity under backpressure: DEPTH + 1 requests.
//  Simultaneous push and pop: both occur, level unchanged.
//  Encoding (op | rs | rt | rd | shamt | funct; I: op|rs|rt|imm16; J: op|imm26):
//   RShift   op=0 funct=0000,sub[1:0]
//   RShiftV  op=0 funct=0001,sub[1:0]
//   RHilo    op=0 funct=010,sub
//   RLong    op=0 funct=011,sub
//   RArith   op=0 funct=1000,sub[1:0]
//   RLogic   op=0 funct=1001,sub[1:0]
//   RComp    op=0 funct=101,sub
//   Branch   sub0-3 op=0001,sub[1:0]; sub4 op=000001; sub5-7 illegal
//   Jump     op=00001,sub[0] J-type
//   Arith    op=00100,sub[0]
//   Comp     op=00101,sub[0]
//   Logic    op=0011,sub[1:0]
//   Load     op=100,sub
//   Store    op=101,sub
//   Other    always illegal
//  Unused high sub bits nonzero (sub[2] for 2-bit cats, sub[2:1] for 1-bit cats) -> illegal.
//  Illegal: outWord=32'h0 (NOP), outIllegal=1; still occupies one output slot.
//  Counters increment on output handshake (outValid & outReady); illegalCount only if
//   outIllegal.
// TESTING
//  1 RArith sub=1 rs=1 rt=2 rd=3 shamt=0 -> outWord 32'h00221821, outIllegal=0, 2nd edge.
//  2 Load sub=3 rs=29 rt=8 imm=4 -> 32'h8FA80004; Jump sub=0 imm=26'h0100000 -> 32'h08100000.
//  3 RArith sub=4, Branch sub=6, Other -> 3 words 32'h0 with outIllegal=1;
//    illegalCount=3, outCount=3.
//  4 outReady=0, inValid=1 for 10 cycles at DEPTH=4 -> exactly 5 accepted, inReady=0,
//    level=4; then outReady=1 -> 5 words in order, one per cycle.
//  5 Full FIFO with outReady=1 and inValid=1 -> inReady stays 0 that cycle;
//    next cycle level=3, push accepted.
//  6 Assert reset with level=3, outValid=1 -> next cycle outValid=0, level=0,
//    counters=0; old words never appear.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// Request/response bundle for the instruction encoder: request side from the
// program generator, encoded-word side toward fetch, plus status counters.
interface instruction_encoder_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int CAT_W = 4
);
    logic                     inValid;
    logic                     inReady;
    logic [CAT_W-1:0]         inCategory;
    logic [2:0]               inSub;
    logic [4:0]               inRs;
    logic [4:0]               inRt;
    logic [4:0]               inRd;
    logic [4:0]               inShamt;
    logic [25:0]              inImm;
    logic                     outValid;
    logic                     outReady;
    logic [31:0]              outWord;
    logic                     outIllegal;
    logic [$clog2(DEPTH):0]   level;
    logic [CNT_W-1:0]         outCount;
    logic [CNT_W-1:0]         illegalCount;

    // Master is the producer/consumer around the encoder; slave is the encoder.
    modport master (
        output inValid, inCategory, inSub, inRs, inRt, inRd, inShamt, inImm, outReady,
        input  inReady, outValid, outWord, outIllegal, level, outCount, illegalCount
    );

    modport slave (
        input  inValid, inCategory, inSub, inRs, inRt, inRd, inShamt, inImm, outReady,
        output inReady, outValid, outWord, outIllegal, level, outCount, illegalCount
    );
endinterface

// File: rtl/instruction_encoder.sv
// Turns {category, sub-op, fields} requests into 32-bit MIPS words through a
// small request FIFO and one registered encode stage; illegal requests become NOPs.
module instruction_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic                   clock,
    input logic                   reset,
    instruction_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CAT_W = 4;

    localparam logic [CAT_W-1:0] RSHIFT_V  = 4'd0;
    localparam logic [CAT_W-1:0] RSHIFTV_V = 4'd1;
    localparam logic [CAT_W-1:0] RHILO_V   = 4'd2;
    localparam logic [CAT_W-1:0] RLONG_V   = 4'd3;
    localparam logic [CAT_W-1:0] RARITH_V  = 4'd4;
    localparam logic [CAT_W-1:0] RLOGIC_V  = 4'd5;
    localparam logic [CAT_W-1:0] RCOMP_V   = 4'd6;
    localparam logic [CAT_W-1:0] BRANCH_V  = 4'd7;
    localparam logic [CAT_W-1:0] JUMP_V    = 4'd8;
    localparam logic [CAT_W-1:0] ARITH_V   = 4'd9;
    localparam logic [CAT_W-1:0] COMP_V    = 4'd10;
    localparam logic [CAT_W-1:0] LOGIC_V   = 4'd11;
    localparam logic [CAT_W-1:0] LOAD_V    = 4'd12;
    localparam logic [CAT_W-1:0] STORE_V   = 4'd13;
    localparam logic [CAT_W-1:0] OTHER_V   = 4'd14;

    typedef struct packed {
        logic [CAT_W-1:0] category;
        logic [2:0]       sub;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [25:0]      imm;
    } req_t;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

    req_t             fifo_q [DEPTH];
    req_t             fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_word_q, out_word_d;
    logic             out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    req_t        in_req;
    req_t        head;
    logic        in_ready;
    logic        push;
    logic        pop;
    logic        out_fire;
    fmt_t        fmt;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] enc_word;
    logic        enc_illegal;

    assign in_req   = '{category: bus.inCategory, sub: bus.inSub, rs: bus.inRs, rt: bus.inRt,
                        rd: bus.inRd, shamt: bus.inShamt, imm: bus.inImm};
    assign head     = fifo_q[rd_ptr_q];
    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push     = bus.inValid && in_ready;
    assign pop      = (level_q != '0) && (!out_valid_q || bus.outReady);
    assign out_fire = out_valid_q && bus.outReady;

    // Encoder for the FIFO head; an unused high sub bit set makes the request illegal.
    always_comb begin
        fmt         = FMT_R;
        op          = 6'b000000;
        funct       = 6'b000000;
        enc_illegal = 1'b0;
        case (head.category)
            RSHIFT_V:  begin funct = {4'b0000, head.sub[1:0]}; enc_illegal = head.sub[2]; end
            RSHIFTV_V: begin funct = {4'b0001, head.sub[1:0]}; enc_illegal = head.sub[2]; end
            RHILO_V:   funct = {3'b010, head.sub};
            RLONG_V:   funct = {3'b011, head.sub};
            RARITH_V:  begin funct = {4'b1000, head.sub[1:0]}; enc_illegal = head.sub[2]; end
            RLOGIC_V:  begin funct = {4'b1001, head.sub[1:0]}; enc_illegal = head.sub[2]; end
            RCOMP_V:   funct = {3'b101, head.sub};
            BRANCH_V: begin
                fmt = FMT_I;
                if (!head.sub[2]) begin
                    op = {4'b0001, head.sub[1:0]};
                end else if (head.sub[1:0] == 2'b00) begin
                    op = 6'b000001;
                end else begin
                    enc_illegal = 1'b1;
                end
            end
            JUMP_V:  begin fmt = FMT_J; op = {5'b00001, head.sub[0]}; enc_illegal = |head.sub[2:1]; end
            ARITH_V: begin fmt = FMT_I; op = {5'b00100, head.sub[0]}; enc_illegal = |head.sub[2:1]; end
            COMP_V:  begin fmt = FMT_I; op = {5'b00101, head.sub[0]}; enc_illegal = |head.sub[2:1]; end
            LOGIC_V: begin fmt = FMT_I; op = {4'b0011, head.sub[1:0]}; enc_illegal = head.sub[2]; end
            LOAD_V:  begin fmt = FMT_I; op = {3'b100, head.sub}; end
            STORE_V: begin fmt = FMT_I; op = {3'b101, head.sub}; end
            OTHER_V: enc_illegal = 1'b1;
            default: enc_illegal = 1'b1;
        endcase

        case (fmt)
            FMT_I:   enc_word = {op, head.rs, head.rt, head.imm[15:0]};
            FMT_J:   enc_word = {op, head.imm};
            default: enc_word = {6'b000000, head.rs, head.rt, head.rd, head.shamt, funct};
        endcase
        if (enc_illegal) begin
            enc_word = 32'h0;
        end
    end

    always_comb begin
        fifo_d          = fifo_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        out_valid_d     = out_valid_q;
        out_word_d      = out_word_q;
        out_illegal_d   = out_illegal_q;
        out_count_d     = out_count_q;
        illegal_count_d = illegal_count_q;

        if (push) begin
            fifo_d[wr_ptr_q] = in_req;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        // The output register refills straight from the head while the consumer drains it.
        if (pop) begin
            out_valid_d   = 1'b1;
            out_word_d    = enc_word;
            out_illegal_d = enc_illegal;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (out_fire) begin
            out_count_d = out_count_q + CNT_W'(1);
            if (out_illegal_q && (illegal_count_q != '1)) begin
                illegal_count_d = illegal_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_q          <= '{default: '0};
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            out_valid_q     <= 1'b0;
            out_word_q      <= 32'h0;
            out_illegal_q   <= 1'b0;
            out_count_q     <= '0;
            illegal_count_q <= '0;
        end else begin
            fifo_q          <= fifo_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            out_valid_q     <= out_valid_d;
            out_word_q      <= out_word_d;
            out_illegal_q   <= out_illegal_d;
            out_count_q     <= out_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign bus.inReady      = in_ready;
    assign bus.outValid     = out_valid_q;
    assign bus.outWord      = out_word_q;
    assign bus.outIllegal   = out_illegal_q;
    assign bus.level        = level_q;
    assign bus.outCount     = out_count_q;
    assign bus.illegalCount = illegal_count_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected words are queued at request
// acceptance and compared as the encoder delivers them.
module tb_instruction_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    localparam logic [3:0] CAT_RSHIFT  = 4'd0;
    localparam logic [3:0] CAT_RSHIFTV = 4'd1;
    localparam logic [3:0] CAT_RHILO   = 4'd2;
    localparam logic [3:0] CAT_RLONG   = 4'd3;
    localparam logic [3:0] CAT_RARITH  = 4'd4;
    localparam logic [3:0] CAT_RLOGIC  = 4'd5;
    localparam logic [3:0] CAT_RCOMP   = 4'd6;
    localparam logic [3:0] CAT_BRANCH  = 4'd7;
    localparam logic [3:0] CAT_JUMP    = 4'd8;
    localparam logic [3:0] CAT_ARITH   = 4'd9;
    localparam logic [3:0] CAT_COMP    = 4'd10;
    localparam logic [3:0] CAT_LOGIC   = 4'd11;
    localparam logic [3:0] CAT_LOAD    = 4'd12;
    localparam logic [3:0] CAT_STORE   = 4'd13;
    localparam logic [3:0] CAT_OTHER   = 4'd14;
    localparam logic [32:0] ILL = {1'b1, 32'h0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] sb_exp;
    int unsigned exp_out_count = 0;
    int unsigned exp_ill_count = 0;

    always #5 clock = ~clock;

    instruction_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    instruction_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Independent reference: opcode/funct as base value plus sub index.
    function automatic logic [32:0] model(input logic [3:0] cat, input logic [2:0] sub,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [25:0] imm);
        logic [31:0] rw;
        rw = {6'd0, rs, rt, rd, sh, 6'd0};
        case (cat)
            CAT_RSHIFT:  return (sub > 3) ? ILL : {1'b0, rw + 32'(sub)};
            CAT_RSHIFTV: return (sub > 3) ? ILL : {1'b0, rw + 32'd4 + 32'(sub)};
            CAT_RHILO:   return {1'b0, rw + 32'd16 + 32'(sub)};
            CAT_RLONG:   return {1'b0, rw + 32'd24 + 32'(sub)};
            CAT_RARITH:  return (sub > 3) ? ILL : {1'b0, rw + 32'd32 + 32'(sub)};
            CAT_RLOGIC:  return (sub > 3) ? ILL : {1'b0, rw + 32'd36 + 32'(sub)};
            CAT_RCOMP:   return {1'b0, rw + 32'd40 + 32'(sub)};
            CAT_BRANCH: begin
                if (sub < 4) return {1'b0, 6'd4 + 6'(sub), rs, rt, imm[15:0]};
                if (sub == 4) return {1'b0, 6'd1, rs, rt, imm[15:0]};
                return ILL;
            end
            CAT_JUMP:  return (sub > 1) ? ILL : {1'b0, 6'd2 + 6'(sub), imm};
            CAT_ARITH: return (sub > 1) ? ILL : {1'b0, 6'd8 + 6'(sub), rs, rt, imm[15:0]};
            CAT_COMP:  return (sub > 1) ? ILL : {1'b0, 6'd10 + 6'(sub), rs, rt, imm[15:0]};
            CAT_LOGIC: return (sub > 3) ? ILL : {1'b0, 6'd12 + 6'(sub), rs, rt, imm[15:0]};
            CAT_LOAD:  return {1'b0, 6'd32 + 6'(sub), rs, rt, imm[15:0]};
            CAT_STORE: return {1'b0, 6'd40 + 6'(sub), rs, rt, imm[15:0]};
            default:   return ILL;
        endcase
    endfunction

    // Scoreboard: inputs change on the falling edge, so 2 units later shows the upcoming handshake.
    always @(negedge clock) begin
        #2;
        if (!reset && bus.outValid && bus.outReady) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_word actual=%h required=none", bus.outWord);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({bus.outIllegal, bus.outWord} !== sb_exp) begin
                    bad++;
                    $display("[TB] FAIL word actual=%b/%h required=%b/%h",
                             bus.outIllegal, bus.outWord, sb_exp[32], sb_exp[31:0]);
                end
            end
            exp_out_count++;
            if (bus.outIllegal && exp_ill_count != 32'hFFFF) exp_ill_count++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called on a falling edge; returns on the next falling edge.
    task automatic drive_cycle(input logic v, input logic [3:0] cat, input logic [2:0] sub,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] sh, input logic [25:0] imm, input logic ordy,
                               input logic [32:0] expv, output logic acc);
        bus.inValid    = v;
        bus.inCategory = cat;
        bus.inSub      = sub;
        bus.inRs       = rs;
        bus.inRt       = rt;
        bus.inRd       = rd;
        bus.inShamt    = sh;
        bus.inImm      = imm;
        bus.outReady   = ordy;
        #1;
        acc = v && bus.inReady;
        if (acc) exp_q.push_back(expv);
        @(negedge clock);
    endtask

    task automatic idle_cycle(input logic ordy);
        logic a;
        drive_cycle(1'b0, CAT_OTHER, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, ordy, ILL, a);
    endtask

    task automatic send_model(input logic [3:0] cat, input logic [2:0] sub, input logic [25:0] imm,
                              input logic ordy, output logic acc);
        drive_cycle(1'b1, cat, sub, 5'd3, 5'd7, 5'd11, 5'd2, imm, ordy,
                    model(cat, sub, 5'd3, 5'd7, 5'd11, 5'd2, imm), acc);
    endtask

    task automatic drain(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !bus.outValid) begin
                ok = 1'b1;
                break;
            end
            idle_cycle(1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.inValid = 1'b0;
        bus.outReady = 1'b0;
        exp_q.delete();
        exp_out_count = 0;
        exp_ill_count = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 7;
        if (bus.level !== 3'd0) begin bad++; $display("[TB] FAIL rst_level actual=%0d required=0", bus.level); end
        if (bus.outValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_outValid actual=%b required=0", bus.outValid); end
        if (bus.outWord !== 32'h0) begin bad++; $display("[TB] FAIL rst_outWord actual=%h required=0", bus.outWord); end
        if (bus.outIllegal !== 1'b0) begin bad++; $display("[TB] FAIL rst_outIllegal actual=%b required=0", bus.outIllegal); end
        if (bus.outCount !== 16'd0) begin bad++; $display("[TB] FAIL rst_outCount actual=%0d required=0", bus.outCount); end
        if (bus.illegalCount !== 16'd0) begin bad++; $display("[TB] FAIL rst_illegalCount actual=%0d required=0", bus.illegalCount); end
        if (bus.inReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_inReady actual=%b required=1", bus.inReady); end
    endtask

    task automatic test_encode();
        logic a;
        logic ok;
        drive_cycle(1'b1, CAT_RARITH, 3'd1, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1, {1'b0, 32'h00221821}, a);
        total += 2;
        if (bus.outValid !== 1'b0) begin bad++; $display("[TB] FAIL lat_edge1_valid actual=%b required=0", bus.outValid); end
        if (bus.level !== 3'd1) begin bad++; $display("[TB] FAIL lat_edge1_level actual=%0d required=1", bus.level); end
        idle_cycle(1'b1);
        total += 2;
        if (bus.outValid !== 1'b1) begin bad++; $display("[TB] FAIL lat_edge2_valid actual=%b required=1", bus.outValid); end
        if (bus.outWord !== 32'h00221821) begin bad++; $display("[TB] FAIL lat_edge2_word actual=%h required=00221821", bus.outWord); end
        drive_cycle(1'b1, CAT_LOAD, 3'd3, 5'd29, 5'd8, 5'd0, 5'd0, 26'd4, 1'b1, {1'b0, 32'h8FA80004}, a);
        drive_cycle(1'b1, CAT_JUMP, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100000, 1'b1, {1'b0, 32'h08100000}, a);
        drain(20, ok);
        total += 2;
        if (!ok) begin bad++; $display("[TB] FAIL encode_drain actual=%0d required=0", exp_q.size()); end
        if (bus.outCount !== 16'd3) begin bad++; $display("[TB] FAIL encode_outCount actual=%0d required=3", bus.outCount); end
    endtask

    task automatic test_illegal();
        logic a;
        logic ok;
        do_reset();
        drive_cycle(1'b1, CAT_RARITH, 3'd4, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1, ILL, a);
        drive_cycle(1'b1, CAT_BRANCH, 3'd6, 5'd1, 5'd2, 5'd0, 5'd0, 26'd9, 1'b1, ILL, a);
        drive_cycle(1'b1, CAT_OTHER, 3'd0, 5'd4, 5'd5, 5'd6, 5'd7, 26'd1, 1'b1, ILL, a);
        drain(20, ok);
        total += 3;
        if (!ok) begin bad++; $display("[TB] FAIL illegal_drain actual=%0d required=0", exp_q.size()); end
        if (bus.illegalCount !== 16'd3) begin bad++; $display("[TB] FAIL illegalCount actual=%0d required=3", bus.illegalCount); end
        if (bus.outCount !== 16'd3) begin bad++; $display("[TB] FAIL illegal_outCount actual=%0d required=3", bus.outCount); end
    endtask

    task automatic test_backpressure();
        logic a;
        int accepted = 0;
        for (int i = 0; i < 10; i++) begin
            send_model(CAT_LOAD, 3'(i), 26'(i + 100), 1'b0, a);
            if (a) accepted++;
        end
        total += 4;
        if (accepted != 5) begin bad++; $display("[TB] FAIL bp_accepted actual=%0d required=5", accepted); end
        if (bus.inReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_inReady actual=%b required=0", bus.inReady); end
        if (bus.level !== 3'd4) begin bad++; $display("[TB] FAIL bp_level actual=%0d required=4", bus.level); end
        if (bus.outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_outValid actual=%b required=1", bus.outValid); end
        for (int i = 0; i < 5; i++) idle_cycle(1'b1);
        total += 3;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL bp_delivered actual=%0d required=0", exp_q.size()); end
        if (bus.outValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_after_valid actual=%b required=0", bus.outValid); end
        if (bus.outCount !== 16'(exp_out_count)) begin bad++; $display("[TB] FAIL bp_outCount actual=%0d required=%0d", bus.outCount, exp_out_count); end
    endtask

    task automatic test_full_simultaneous();
        logic a;
        logic ok;
        for (int i = 0; i < 5; i++) send_model(CAT_STORE, 3'(i), 26'(i + 7), 1'b0, a);
        send_model(CAT_LOGIC, 3'd2, 26'h1234, 1'b1, a);
        total += 2;
        if (a !== 1'b0) begin bad++; $display("[TB] FAIL full_push actual=%b required=0", a); end
        if (bus.level !== 3'd3) begin bad++; $display("[TB] FAIL full_level actual=%0d required=3", bus.level); end
        send_model(CAT_ARITH, 3'd1, 26'h0BEEF, 1'b1, a);
        total += 2;
        if (a !== 1'b1) begin bad++; $display("[TB] FAIL pushpop_push actual=%b required=1", a); end
        if (bus.level !== 3'd3) begin bad++; $display("[TB] FAIL pushpop_level actual=%0d required=3", bus.level); end
        drain(30, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL full_drain actual=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic a;
        logic ok;
        logic [3:0] cat;
        logic [2:0] sub;
        logic [4:0] rs, rt, rd, sh;
        logic [25:0] imm;
        for (int i = 0; i < 200; i++) begin
            cat = 4'($urandom_range(0, 15));
            sub = 3'($urandom_range(0, 7));
            rs  = 5'($urandom);
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            sh  = 5'($urandom);
            imm = 26'($urandom);
            drive_cycle(1'($urandom_range(0, 1)), cat, sub, rs, rt, rd, sh, imm,
                        ($urandom_range(0, 3) != 0), model(cat, sub, rs, rt, rd, sh, imm), a);
        end
        drain(40, ok);
        total += 3;
        if (!ok) begin bad++; $display("[TB] FAIL b2b_drain actual=%0d required=0", exp_q.size()); end
        if (bus.outCount !== 16'(exp_out_count)) begin bad++; $display("[TB] FAIL b2b_outCount actual=%0d required=%0d", bus.outCount, exp_out_count); end
        if (bus.illegalCount !== 16'(exp_ill_count)) begin bad++; $display("[TB] FAIL b2b_illegalCount actual=%0d required=%0d", bus.illegalCount, exp_ill_count); end
    endtask

    task automatic test_reset_midstream();
        logic a;
        for (int i = 0; i < 4; i++) send_model(CAT_RHILO, 3'(i), 26'd0, 1'b0, a);
        total += 3;
        if (bus.level !== 3'd3) begin bad++; $display("[TB] FAIL pre_rst_level actual=%0d required=3", bus.level); end
        if (bus.outValid !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_valid actual=%b required=1", bus.outValid); end
        if (bus.outCount === 16'd0) begin bad++; $display("[TB] FAIL pre_rst_outCount actual=0 required=nonzero"); end
        reset = 1'b1;
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        exp_q.delete();
        exp_out_count = 0;
        exp_ill_count = 0;
        @(negedge clock);
        total += 4;
        if (bus.outValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid actual=%b required=0", bus.outValid); end
        if (bus.level !== 3'd0) begin bad++; $display("[TB] FAIL mid_rst_level actual=%0d required=0", bus.level); end
        if (bus.outCount !== 16'd0) begin bad++; $display("[TB] FAIL mid_rst_outCount actual=%0d required=0", bus.outCount); end
        if (bus.illegalCount !== 16'd0) begin bad++; $display("[TB] FAIL mid_rst_illegalCount actual=%0d required=0", bus.illegalCount); end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) idle_cycle(1'b1);
        total += 2;
        if (bus.outValid !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_valid actual=%b required=0", bus.outValid); end
        if (bus.level !== 3'd0) begin bad++; $display("[TB] FAIL post_rst_level actual=%0d required=0", bus.level); end
    endtask

    initial begin
        bus.inValid    = 1'b0;
        bus.inCategory = CAT_OTHER;
        bus.inSub      = 3'd0;
        bus.inRs       = 5'd0;
        bus.inRt       = 5'd0;
        bus.inRd       = 5'd0;
        bus.inShamt    = 5'd0;
        bus.inImm      = 26'd0;
        bus.outReady   = 1'b0;
        @(negedge clock);
        test_reset();
        test_encode();
        test_illegal();
        test_backpressure();
        test_full_simultaneous();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
